// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state encoding, PC increments and the queue entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] R15_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order DEPTH-entry instruction queue; pushed data is readable from the next cycle.
// A push is dropped only when full with no pop in the same cycle; flush beats push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  entry_t                     i_dat,
  output entry_t                     o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_dat;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem valid/ready requests, in-order queue to decode, PCSrc redirect; 1-cycle latency.
// Requests stop while the queue is full; FETCH_BYPASS_EN adds a zero-latency path when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc8,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] branch_target
);

  localparam int            CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH-1);

  state_t        r_state;
  logic          r_imem_req;
  logic [31:0]   r_fpc;

  entry_t        w_head;
  entry_t        w_push_dat;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_hs;
  logic          w_push;
  logic          w_qpop;
  logic          w_byp;
  logic          w_byp_take;
  logic          w_unused;

  assign w_hs   = r_imem_req & imem_ready;
  assign w_qpop = ~w_empty & instr_ready;

`ifdef FETCH_BYPASS_EN
  assign w_byp      = w_empty & w_hs & ~PCSrc;
  assign w_byp_take = w_byp & instr_ready;
`else
  assign w_byp      = 1'b0;
  assign w_byp_take = 1'b0;
`endif

  // A redirect discards the word returned in the same cycle.
  assign w_push          = w_hs & ~PCSrc & ~w_byp_take;
  assign w_push_dat.word = imem_rdata;
  assign w_push_dat.pc   = r_fpc;

  assign w_unused = &{1'b0, branch_target[1:0]};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_qpop),
    .i_flush (PCSrc),
    .i_dat   (w_push_dat),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_fpc;
  assign instr_valid = ~w_empty | w_byp;
  assign instr       = w_byp ? imem_rdata : w_head.word;
  assign instr_pc    = w_byp ? r_fpc      : w_head.pc;
  assign instr_pc8   = instr_pc + R15_OFFSET;

  // Only FETCH raises a request and FETCH is left the moment the last slot fills,
  // so every issued request has a free slot at push time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= BOOT;
      r_imem_req <= 1'b0;
      r_fpc      <= RESET_PC;
    end else if (PCSrc) begin
      r_state    <= FETCH;
      r_imem_req <= 1'b1;
      r_fpc      <= {branch_target[31:2], 2'b00};
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (w_hs) begin
            r_fpc <= r_fpc + PC_INC;
            if (w_push && !w_qpop && (w_count == LAST)) begin
              r_state    <= FULL;
              r_imem_req <= 1'b0;
            end
          end
        end
        FULL: begin
          if (w_qpop || !w_full) begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): scoreboard of delivered {word, pc} plus control-signal checks.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc8;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] branch_target;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pc8;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc8     (instr_pc8),
    .instr_ready   (instr_ready),
    .PCSrc         (PCSrc),
    .branch_target (branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory: each address returns a distinct word.
  assign imem_rdata = word_of(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc, input logic [31:0] pc8);
    exp_t e;
    e.word = word_of(pc);
    e.pc   = pc;
    e.pc8  = pc8;
    exp_q.push_back(e);
  endtask

  // One cycle: drive just after the rising edge, then move to the falling edge for checks.
  task automatic cyc(input logic mr, input logic ir, input logic ps, input logic [31:0] bt);
    @(posedge clk);
    #1;
    imem_ready    = mr;
    instr_ready   = ir;
    PCSrc         = ps;
    branch_target = bt;
    @(negedge clk);
  endtask

  // Monitor: every consumed head instruction must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %h with nothing expected", instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.word);
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_pc8", instr_pc8, e.pc8);
      end
    end
  end

  initial begin
    reset         = 1'b0;
    imem_ready    = 1'b0;
    instr_ready   = 1'b0;
    PCSrc         = 1'b0;
    branch_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_pc8", instr_pc8, 32'h8);

    // Cycle 0 (BOOT) after release.
    @(posedge clk);
    #1;
    reset       = 1'b1;
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("boot_req", {31'b0, imem_req}, 32'd0);

    // Streaming: one request and one delivery per cycle.
    cyc(1, 1, 0, 0); expect_pc(32'h100, 32'h108);
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h100);
    chk("c1_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1, 1, 0, 0); expect_pc(32'h104, 32'h10C);
    chk("c2_addr", imem_addr, 32'h104);
    chk("c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("c2_pc8", instr_pc8, 32'h108);
    cyc(1, 1, 0, 0); expect_pc(32'h108, 32'h110);
    chk("c3_addr", imem_addr, 32'h108);

    // Memory stalls three cycles: address held, nothing pushed.
    cyc(0, 1, 0, 0);
    chk("stall0_addr", imem_addr, 32'h10C);
    chk("stall0_req", {31'b0, imem_req}, 32'd1);
    cyc(0, 1, 0, 0);
    chk("stall1_addr", imem_addr, 32'h10C);
    chk("stall1_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 1, 0, 0);
    chk("stall2_addr", imem_addr, 32'h10C);
    chk("stall2_valid", {31'b0, instr_valid}, 32'd0);

    // Decode stalls: four handshakes fill the queue, then requests stop.
    cyc(1, 0, 0, 0); expect_pc(32'h10C, 32'h114);
    chk("fill0_addr", imem_addr, 32'h10C);
    chk("fill0_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1, 0, 0, 0); expect_pc(32'h110, 32'h118);
    chk("fill1_valid", {31'b0, instr_valid}, 32'd1);
    chk("fill1_pc", instr_pc, 32'h10C);
    chk("fill1_instr", instr, word_of(32'h10C));
    cyc(1, 0, 0, 0); expect_pc(32'h114, 32'h11C);
    cyc(1, 0, 0, 0);
    chk("fill3_req", {31'b0, imem_req}, 32'd1);
    chk("fill3_addr", imem_addr, 32'h118);
    cyc(1, 0, 0, 0);
    chk("full0_req", {31'b0, imem_req}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("full1_req", {31'b0, imem_req}, 32'd0);
    chk("full1_head", instr_pc, 32'h10C);

    // One pop re-opens fetching for a single request.
    cyc(1, 1, 0, 0);
    chk("pop_req", {31'b0, imem_req}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("refill_req", {31'b0, imem_req}, 32'd1);
    chk("refill_addr", imem_addr, 32'h11C);
    chk("refill_head", instr_pc, 32'h110);
    cyc(1, 0, 0, 0);
    chk("refull_req", {31'b0, imem_req}, 32'd0);

    // Pop 0x110, then redirect with 3 queued entries, a same-cycle pop and handshake.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 32'h0000_0203);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr_pre", imem_addr, 32'h120);
    chk("redir_count3", {31'b0, instr_valid}, 32'd1);
    cyc(1, 1, 0, 0); expect_pc(32'h200, 32'h208);
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h200);

    // Redirect to the top word, then check the wrap of fpc and pc8.
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    chk("tgt_valid", {31'b0, instr_valid}, 32'd1);
    cyc(1, 0, 0, 0); expect_pc(32'hFFFF_FFFC, 32'h0000_0004);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("top_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc8", instr_pc8, 32'h4);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    chk("pre_rst_valid", {31'b0, instr_valid}, 32'd0);

    // Asynchronous reset in the middle of a FETCH cycle.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h100);
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the controller and datapath decode. It holds the fetch PC, issues word requests to instruction memory over a valid/ready handshake, and buffers returned words in a small in-order queue. It presents the head instruction, its PC and PC+8 to decode, and flushes and redirects on a taken branch (PCSrc) from the condition logic.

## Interface
- DEPTH, 4: instruction queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; [1:0] always 2'b00.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  queue head is valid.
- instr  out  32  head instruction; bits [31:12] feed the controller.
- instr_pc  out  32  address of the head instruction.
- instr_pc8  out  32  instr_pc + 8, the R15 read value.
- instr_ready  in  1  decode consumes the head this cycle.
- PCSrc  in  1  taken branch/PC write; redirects fetch.
- branch_target  in  32  redirect address; bits [1:0] are ignored and forced to 0.

## Operation
- Fetch PC register fpc; queue entries hold {word, pc}; count is 0..DEPTH.
- FSM states, encoded in fetch_pkg:
  - BOOT: the single cycle after reset deassertion; imem_req=0. Next state FETCH.
  - FETCH: imem_req=1 with imem_addr=fpc. On handshake (imem_req & imem_ready), push {imem_rdata, fpc} and set fpc += 4. Go to FULL when the push makes count==DEPTH with no pop in the same cycle.
  - FULL: imem_req=0. Return to FETCH on any pop.
- imem_addr is held stable while imem_req=1 and imem_ready=0. Only a redirect may change it.
- Pop occurs on instr_valid & instr_ready. Push and pop in the same cycle leave count unchanged.
- A request is never issued unless one free slot is guaranteed at push time: count<DEPTH, or count==DEPTH with a pop in the same cycle.
- Redirect (PCSrc=1) has priority over all other events:
  - Queue is emptied, including any same-cycle push, which is discarded.
  - fpc <= {branch_target[31:2], 2'b00}; next state is FETCH.
  - A same-cycle pop still counts as consumed, with no side effects.
  - Outputs are valid again no earlier than one handshake later.
- fpc wraps from 32'hFFFF_FFFC to 0 with no flag. instr_pc8 wraps modulo 2^32.
- Reset values (asynchronous, while reset=0):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_pc8=8.
  - State BOOT, count=0, fpc=RESET_PC.
- A reset asserted mid-transaction abandons the outstanding request. Memory must tolerate imem_req dropping asynchronously.

## Timing
- Earliest first request: cycle 1 after reset release. BOOT is cycle 0.
- Latency with the bypass feature compiled out: handshake in cycle N gives instr_valid in cycle N+1.
- Sustained throughput: one instruction per cycle when imem_ready=1 and instr_ready=1 continuously.
- PCSrc sampled in cycle N: imem_addr=target in cycle N+1, and instr_valid=0 in cycle N+1.
- All outputs are registered except under FETCH_BYPASS_EN.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty, a handshake occurs, and PCSrc=0, imem_rdata and its PC drive instr/instr_pc combinationally.
  - instr_valid=1 in the same cycle.
  - If instr_ready=1, the word is consumed and not pushed; otherwise it is pushed.
  - Zero-cycle fetch latency.
- FETCH_BYPASS_EN undefined: all outputs come from queue registers; minimum latency is 1 cycle.

## Structure
- fetch_pkg holds:
  - state typedef (BOOT, FETCH, FULL);
  - PC_INC=4 and R15_OFFSET=8;
  - queue entry struct {word, pc}.
- Sub-module fetch_queue: DEPTH-entry synchronous FIFO with push, pop, flush, count, full and empty. Pointers wrap modulo DEPTH; flush has priority over push.
- fetch_unit holds fpc, the FSM, the handshake logic, the redirect logic and the optional bypass.

## Test plan
- Reset release, RESET_PC=0x100, imem_ready=1, instr_ready=1 → requests at 0x100, 0x104, 0x108 on consecutive cycles. First instr_valid one cycle after the 0x100 handshake; instr_pc8=0x108.
- instr_ready=0, DEPTH=4 → exactly 4 handshakes, then imem_req=0 (FULL). One pop → imem_req=1 the next cycle; head order preserved.
- imem_ready=0 for 3 cycles → imem_addr is held constant and no push occurs. Ready in the 4th cycle → a single push.
- PCSrc=1 with branch_target=0x203 while the queue holds 3 entries and a handshake occurs in the same cycle → next cycle: instr_valid=0, imem_addr=0x200, queue empty, handshake data not delivered.
- fpc=0xFFFF_FFFC handshake → next imem_addr=0x0. Head instr_pc=0xFFFF_FFFC with instr_pc8=0x4.
- With FETCH_BYPASS_EN, empty queue and instr_ready=1 → instr equals imem_rdata in the handshake cycle and count stays 0. Asynchronous reset asserted mid-FETCH → imem_req=0 immediately.
